// File: rtl/mux_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mux_ctrl_pkg
// Shared definitions for the round-robin mux arbiter:
//   state_e          - two-state ownership FSM encoding (IDLE / OWN)
//   NUM_REQ, IDX_W   - requester count and index width
//   DEFAULT_MAX_HOLD - default cap on consecutive ownership cycles
// ---------------------------------------------------------------------------
package mux_ctrl_pkg;

    localparam int NUM_REQ          = 16;
    localparam int IDX_W            = 4;
    localparam int DEFAULT_MAX_HOLD = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_e;

endpackage

// File: rtl/mux16to1.sv
// ---------------------------------------------------------------------------
// mux16to1
// Plain 16:1 single-bit multiplexer.
// Ports:
//   data_i [0:15] - data bits, element i is input i
//   sel_i  [3:0]  - binary select
//   data_o        - data_i[sel_i]
// ---------------------------------------------------------------------------
module mux16to1 (
    input  logic [0:15] data_i,
    input  logic [3:0]  sel_i,
    output logic        data_o
);

    assign data_o = data_i[sel_i];

endmodule

// File: rtl/rr_mux_arbiter.sv
// ---------------------------------------------------------------------------
// rr_mux_arbiter
// Round-robin arbiter owning a 16:1 data mux. A requester keeps the mux until
// it signals done, drops its request, or has held it for MAX_HOLD cycles.
// Ports:
//   clk        - clock, all state updates on the rising edge
//   rst_n      - synchronous active-low reset
//   req  [0:15]- request per requester (element i = requester i)
//   done       - owner-finished strobe, only looked at while gnt_valid=1
//   data_in[0:15] - one data bit per requester
//   sel  [0:3] - registered binary owner index (sel[0] is the MSB)
//   gnt  [0:15]- registered one-hot grant, zero when idle
//   gnt_valid  - registered, high while an owner holds the mux
//   data_out   - data_in[sel] gated by gnt_valid
//   timeout    - one-cycle pulse after a grant revoked by the hold limit
// ---------------------------------------------------------------------------
module rr_mux_arbiter
    import mux_ctrl_pkg::*;
#(
    parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [0:NUM_REQ-1] req,
    input  logic               done,
    input  logic [0:NUM_REQ-1] data_in,
    output logic [0:IDX_W-1]   sel,
    output logic [0:NUM_REQ-1] gnt,
    output logic               gnt_valid,
    output logic               data_out,
    output logic               timeout
);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   sel_q, sel_d;
    logic [IDX_W-1:0]   hold_q, hold_d;
    logic               timeout_q, timeout_d;
    logic [0:NUM_REQ-1] gnt_q, gnt_d;

    logic               owner_req;
    logic               hold_limit;
    logic               release_now;
    logic [IDX_W-1:0]   scan_ptr;
    logic [IDX_W-1:0]   scan_cand;
    logic [IDX_W-1:0]   scan_idx;
    logic               scan_found;
    logic               mux_bit;

    // ---------------------------------------------------------------------
    // Release conditions for the current owner
    // ---------------------------------------------------------------------
    assign owner_req   = req[sel_q];
    assign hold_limit  = (hold_q == IDX_W'(MAX_HOLD - 1));
    assign release_now = (state_q == ST_OWN) && (done || !owner_req || hold_limit);

    // On release the search starts just past the outgoing owner, so the
    // scan uses the pointer value that will be committed this cycle.
    assign scan_ptr = release_now ? (sel_q + IDX_W'(1)) : ptr_q;

    // ---------------------------------------------------------------------
    // Round-robin priority scan: first requester at or after scan_ptr,
    // wrapping modulo 16 through the 4-bit addition.
    // ---------------------------------------------------------------------
    always_comb begin
        scan_found = 1'b0;
        scan_idx   = '0;
        scan_cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_cand = scan_ptr + IDX_W'(k);
            if (!scan_found && req[scan_cand]) begin
                scan_found = 1'b1;
                scan_idx   = scan_cand;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Next-state / next-output logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        hold_d    = hold_q;
        // Only a pure hold-limit release raises timeout; done or a dropped
        // request take precedence.
        timeout_d = (state_q == ST_OWN) && hold_limit && !done && owner_req;

        unique case (state_q)
            ST_IDLE: begin
                if (scan_found) begin
                    state_d = ST_OWN;
                    sel_d   = scan_idx;
                    hold_d  = '0;
                end
            end
            ST_OWN: begin
                if (release_now) begin
                    ptr_d  = sel_q + IDX_W'(1);
                    hold_d = '0;
                    if (scan_found) begin
                        // Back-to-back handover, no idle bubble.
                        sel_d = scan_idx;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    hold_d = hold_q + IDX_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // One-hot grant decoded from the next owner so gnt is registered
    // alongside sel and can never disagree with it.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_gnt
            assign gnt_d[gi] = (state_d == ST_OWN) && (sel_d == IDX_W'(gi));
        end
    endgenerate

    // ---------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            sel_q     <= '0;
            hold_q    <= '0;
            timeout_q <= 1'b0;
            gnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
            gnt_q     <= gnt_d;
        end
    end

    // ---------------------------------------------------------------------
    // Data path
    // ---------------------------------------------------------------------
    mux16to1 u_mux (
        .data_i (data_in),
        .sel_i  (sel_q),
        .data_o (mux_bit)
    );

    assign sel       = sel_q;
    assign gnt       = gnt_q;
    assign gnt_valid = (state_q == ST_OWN);
    assign timeout   = timeout_q;
    assign data_out  = mux_bit & gnt_valid;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_mux_arbiter
// Table-driven vectors, hand-written multi-cycle sequences and a randomized
// run checked against a cycle-level behavioural model of the arbiter.
// ---------------------------------------------------------------------------
module tb_rr_mux_arbiter;

    localparam int MAX_HOLD = 8;

    logic        clk;
    logic        rst_n;
    logic [0:15] req;
    logic        done;
    logic [0:15] data_in;
    logic [0:3]  sel;
    logic [0:15] gnt;
    logic        gnt_valid;
    logic        data_out;
    logic        timeout;

    int tests;
    int failed;
    int cyc;

    rr_mux_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .data_in   (data_in),
        .sel       (sel),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .data_out  (data_out),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------------
    // Behavioural model: who owns the mux, for how many cycles so far,
    // and where the next search starts.
    // ---------------------------------------------------------------------
    int m_owner;
    int m_ptr;
    int m_held;     // cycles the current owner has held the mux
    bit m_busy;
    bit m_to;

    function automatic int first_req(input logic [0:15] r, input int from);
        for (int k = 0; k < 16; k++) begin
            int i = (from + k) % 16;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [0:15] onehot(input int idx);
        logic [0:15] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    task automatic model_edge();
        int f;
        bit lim, drop;
        if (!rst_n) begin
            m_busy = 0; m_owner = 0; m_ptr = 0; m_held = 0; m_to = 0;
        end else if (!m_busy) begin
            m_to = 0;
            f = first_req(req, m_ptr);
            if (f >= 0) begin
                m_busy = 1; m_owner = f; m_held = 1;
            end
        end else begin
            lim  = (m_held == MAX_HOLD);
            drop = !req[m_owner];
            m_to = lim && !done && !drop;
            if (done || drop || lim) begin
                m_ptr = (m_owner + 1) % 16;
                f = first_req(req, m_ptr);
                if (f >= 0) begin
                    m_owner = f; m_held = 1;
                end else begin
                    m_busy = 0; m_held = 0;
                end
            end else begin
                m_held++;
            end
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic compare_model();
        logic [0:15] e_gnt;
        e_gnt = m_busy ? onehot(m_owner) : 16'h0000;
        check("model_valid", int'(gnt_valid), int'(m_busy));
        check("model_sel", int'(sel), m_owner);
        check("model_gnt", int'(gnt), int'(e_gnt));
        check("model_timeout", int'(timeout), int'(m_to));
        check("model_dout", int'(data_out), m_busy ? int'(data_in[m_owner]) : 0);
    endtask

    // One clock: model advances with the inputs present at the edge,
    // outputs are sampled 1 time unit after the edge.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        compare_model();
        $display("[TB] cyc=%0d rst_n=%0b req=%04h done=%0b din=%04h -> valid=%0b sel=%0d gnt=%04h to=%0b dout=%0b",
                 cyc, rst_n, req, done, data_in, gnt_valid, sel, gnt, timeout, data_out);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = '0; done = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic expect_out(input string name, input bit e_valid, input int e_sel, input bit e_to);
        check({name, "_valid"}, int'(gnt_valid), int'(e_valid));
        check({name, "_sel"}, int'(sel), e_sel);
        check({name, "_timeout"}, int'(timeout), int'(e_to));
    endtask

    // ---------------------------------------------------------------------
    // Vector table: one row per clock, expectations after that edge.
    // ---------------------------------------------------------------------
    typedef struct {
        logic        rst_n;
        logic [0:15] req;
        logic        done;
        logic [0:15] din;
        logic        e_valid;
        int          e_sel;
        logic        e_to;
        logic        e_dout;
    } vec_t;

    vec_t tbl[11];

    initial begin
        logic [0:15] e_gnt;
        tests = 0; failed = 0; cyc = 0;
        m_owner = 0; m_ptr = 0; m_held = 0; m_busy = 0; m_to = 0;
        rst_n = 1'b0; req = '0; done = 1'b0; data_in = '0;

        tbl[0]  = '{1'b0, 16'h0000, 1'b0, 16'hA5A5, 1'b0, 0, 1'b0, 1'b0}; // reset state
        tbl[1]  = '{1'b1, 16'h8000, 1'b0, 16'hA5A5, 1'b1, 0, 1'b0, 1'b1}; // req index 0
        tbl[2]  = '{1'b1, 16'h0000, 1'b0, 16'hA5A5, 1'b0, 0, 1'b0, 1'b0}; // drop -> idle
        tbl[3]  = '{1'b1, 16'h2000, 1'b0, 16'hA5A5, 1'b1, 2, 1'b0, 1'b1}; // index 2 -> dout 1
        tbl[4]  = '{1'b1, 16'h4000, 1'b1, 16'hA5A5, 1'b1, 1, 1'b0, 1'b0}; // index 1 -> dout 0
        tbl[5]  = '{1'b1, 16'h0400, 1'b1, 16'hA5A5, 1'b1, 5, 1'b0, 1'b1}; // owner 5, cycle 1
        tbl[6]  = '{1'b1, 16'h0600, 1'b0, 16'hA5A5, 1'b1, 5, 1'b0, 1'b1}; // cycle 2
        tbl[7]  = '{1'b1, 16'h0600, 1'b0, 16'hA5A5, 1'b1, 5, 1'b0, 1'b1}; // cycle 3
        tbl[8]  = '{1'b1, 16'h0200, 1'b0, 16'hA5A5, 1'b1, 6, 1'b0, 1'b0}; // 5 drops -> 6
        tbl[9]  = '{1'b0, 16'h0200, 1'b0, 16'hA5A5, 1'b0, 0, 1'b0, 1'b0}; // reset mid-own
        tbl[10] = '{1'b1, 16'h0000, 1'b0, 16'hA5A5, 1'b0, 0, 1'b0, 1'b0}; // idle after reset

        for (int i = 0; i < 11; i++) begin
            rst_n   = tbl[i].rst_n;
            req     = tbl[i].req;
            done    = tbl[i].done;
            data_in = tbl[i].din;
            step();
            e_gnt = tbl[i].e_valid ? onehot(tbl[i].e_sel) : 16'h0000;
            check($sformatf("vec%0d_valid", i), int'(gnt_valid), int'(tbl[i].e_valid));
            check($sformatf("vec%0d_sel", i), int'(sel), tbl[i].e_sel);
            check($sformatf("vec%0d_gnt", i), int'(gnt), int'(e_gnt));
            check($sformatf("vec%0d_timeout", i), int'(timeout), int'(tbl[i].e_to));
            check($sformatf("vec%0d_dout", i), int'(data_out), int'(tbl[i].e_dout));
        end

        // Requesters 3 and 9 with done every cycle: strict alternation.
        do_reset();
        req = 16'h1040; done = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            expect_out($sformatf("alt%0d", i), 1'b1, (i % 2 == 0) ? 3 : 9, 1'b0);
        end

        // Requester 15 alone, no done: 8-cycle grant, timeout, re-grant.
        do_reset();
        req = 16'h0001; done = 1'b0;
        for (int i = 0; i < MAX_HOLD; i++) begin
            step();
            expect_out($sformatf("hold%0d", i), 1'b1, 15, 1'b0);
        end
        step();
        expect_out("regrant15", 1'b1, 15, 1'b1);
        req = 16'h0000;
        step();
        expect_out("drop15", 1'b0, 15, 1'b0);
        // Pointer wrapped to 0: requester 0 beats requester 15.
        req = 16'h8001;
        step();
        expect_out("wrap", 1'b1, 0, 1'b0);

        // done coinciding with the hold limit is a normal release.
        req = 16'h8000;
        for (int i = 0; i < MAX_HOLD - 1; i++) step();
        done = 1'b1;
        step();
        expect_out("done_at_limit", 1'b1, 0, 1'b0);
        done = 1'b0;

        // Randomized run against the model.
        for (int n = 0; n < 2500; n++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 7) == 0)
                req = 16'($urandom & $urandom);
            done    = ($urandom_range(0, 7) == 0);
            data_in = 16'($urandom);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
